// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-way round-robin sequencer for the word memory data port with byte-enable RMW
module data_mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_we,
  input  logic [1:0][ADDR_W-1:0]      req_addr,
  input  logic [1:0][3:0]             req_be,
  input  logic [1:0][DATA_W-1:0]      req_wdata,
  output logic [1:0]                  rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, RESP} state_t;
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t state, state_d;
  logic prio, gnt, acc, a_we, g_q, we_q;
  logic [3:0] a_be, be_q;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] wdata_q, merged;
  // arbitration: single requester wins outright, contention resolved by prio
  always_comb begin
    gnt = &req_valid ? prio : req_valid[1];
    acc = rst_n && state == IDLE && |req_valid;
    a_we = req_we[gnt];
    a_be = req_be[gnt];
    req_ready = acc ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  end
  // byte-lane merge of store data over the word just read back
  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // next-state: loads and partial stores read first, full stores write directly, empty stores just respond
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (acc) state_d = !a_we ? RD_ISSUE : a_be == 4'h0 ? RESP : a_be == 4'hf ? WR : RD_ISSUE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (cnt == '0) state_d = we_q ? WR : RESP;
      WR:       state_d = RESP;
      default:  state_d = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    mem_we = state == WR;
    rsp_valid = state == RESP ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  end
  // transaction latch, read-latency counter and registered memory/response data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= 1'b0;
      g_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (acc) begin
        prio <= ~gnt;
        g_q <= gnt;
        we_q <= a_we;
        be_q <= a_be;
        wdata_q <= req_wdata[gnt];
        if (!a_we || a_be != 4'h0) mem_addr <= req_addr[gnt];
        if (a_we && a_be == 4'hf) mem_wdata <= req_wdata[gnt];
        if (a_we && a_be == 4'h0) rsp_rdata <= '0;
      end
      if (state == RD_ISSUE) cnt <= CW'(MEM_LAT - 1);
      if (state == RD_WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          rsp_rdata <= we_q ? merged : mem_rdata;
          if (we_q) mem_wdata <= merged;
        end
      end
      if (state == WR && be_q == 4'hf) rsp_rdata <= wdata_q;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter against a latency-2 word memory model
module tb_data_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [1:0][AW-1:0] req_addr = '0;
  logic [1:0][3:0] req_be = '0;
  logic [1:0][DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata, p1, p2;
  logic [AW-1:0] mem_addr;
  logic mem_we, busy;
  logic [DW-1:0] mem [0:2**AW-1];
  logic pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb[$];
  int sb_g[$];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pre_en) mem[pre_addr] <= pre_data;
    p1 <= mem[mem_addr];
    p2 <= p1;
  end
  assign mem_rdata = p2;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input int r, input logic we, input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [DW-1:0] wd, output int wait_c, output int rsp_c,
                       output logic [1:0] rv, output logic [DW-1:0] rd, output logic [15:0] wm);
    req_we[r] = we;
    req_addr[r] = a;
    req_be[r] = be;
    req_wdata[r] = wd;
    req_valid[r] = 1'b1;
    wait_c = -1;
    rsp_c = 0;
    rv = '0;
    rd = '0;
    wm = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        wait_c = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (wait_c < 0) return;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      wm[c] = mem_we;
      if (rsp_valid != 2'b00) begin
        rsp_c = c;
        rv = rsp_valid;
        rd = rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_ctrl: busy=%b we=%b rv=%b want 0 0 00", busy, mem_we, rsp_valid); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0 || rsp_rdata !== '0) begin n_bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    int w, rc;
    logic [1:0] rv;
    logic [DW-1:0] rd;
    logic [15:0] wm;
    preload(14'h010, 32'hDEADBEEF);
    sb.push_back(32'hDEADBEEF);
    issue(0, 1'b0, 14'h010, 4'h0, '0, w, rc, rv, rd, wm);
    n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL load_ready_c0: waited %0d want 0", w); end
    n_cmp++; if (wm !== 16'h0000) begin n_bad++; $display("FAIL load_no_we: we mask %h want 0000", wm); end
    n_cmp++; if (rc !== 4 || rv !== 2'b01) begin n_bad++; $display("FAIL load_rsp: cycle %0d valid %b want 4 01", rc, rv); end
    n_cmp++; if (rd !== sb.pop_front()) begin n_bad++; $display("FAIL load_data: got %h want DEADBEEF", rd); end
  endtask

  task automatic test_full_store();
    int w, rc;
    logic [1:0] rv;
    logic [DW-1:0] rd;
    logic [15:0] wm;
    sb.push_back(32'h12345678);
    issue(1, 1'b1, 14'h3FFF, 4'hF, 32'h12345678, w, rc, rv, rd, wm);
    n_cmp++; if (wm !== 16'h0002) begin n_bad++; $display("FAIL full_we: we mask %h want 0002", wm); end
    n_cmp++; if (rc !== 2 || rv !== 2'b10) begin n_bad++; $display("FAIL full_rsp: cycle %0d valid %b want 2 10", rc, rv); end
    n_cmp++; if (rd !== sb.pop_front()) begin n_bad++; $display("FAIL full_data: got %h want 12345678", rd); end
    sb.push_back(32'h12345678);
    issue(1, 1'b0, 14'h3FFF, 4'h0, '0, w, rc, rv, rd, wm);
    n_cmp++; if (rc !== 4 || rv !== 2'b10) begin n_bad++; $display("FAIL full_readback_rsp: cycle %0d valid %b want 4 10", rc, rv); end
    n_cmp++; if (rd !== sb.pop_front()) begin n_bad++; $display("FAIL full_readback: got %h want 12345678", rd); end
  endtask

  task automatic test_partial_store();
    int w, rc;
    logic [1:0] rv;
    logic [DW-1:0] rd;
    logic [15:0] wm;
    preload(14'h020, 32'hAABBCCDD);
    sb.push_back(32'hAA22CC44);
    issue(0, 1'b1, 14'h020, 4'b0101, 32'h11223344, w, rc, rv, rd, wm);
    n_cmp++; if (wm !== 16'h0010) begin n_bad++; $display("FAIL partial_we: we mask %h want 0010", wm); end
    n_cmp++; if (rc !== 5 || rv !== 2'b01) begin n_bad++; $display("FAIL partial_rsp: cycle %0d valid %b want 5 01", rc, rv); end
    n_cmp++; if (rd !== sb.pop_front()) begin n_bad++; $display("FAIL partial_data: got %h want AA22CC44", rd); end
    n_cmp++; if (mem[14'h020] !== 32'hAA22CC44) begin n_bad++; $display("FAIL partial_mem: got %h want AA22CC44", mem[14'h020]); end
  endtask

  task automatic test_zero_be();
    int w, rc;
    logic [1:0] rv;
    logic [DW-1:0] rd;
    logic [15:0] wm;
    preload(14'h030, 32'h55AA55AA);
    sb.push_back(32'h0);
    issue(1, 1'b1, 14'h030, 4'h0, 32'hFFFFFFFF, w, rc, rv, rd, wm);
    n_cmp++; if (rc !== 1 || rv !== 2'b10) begin n_bad++; $display("FAIL zero_rsp: cycle %0d valid %b want 1 10", rc, rv); end
    n_cmp++; if (wm !== 16'h0000) begin n_bad++; $display("FAIL zero_we: we mask %h want 0000", wm); end
    n_cmp++; if (rd !== sb.pop_front()) begin n_bad++; $display("FAIL zero_data: got %h want 00000000", rd); end
    n_cmp++; if (mem[14'h030] !== 32'h55AA55AA) begin n_bad++; $display("FAIL zero_mem: got %h want 55AA55AA", mem[14'h030]); end
  endtask

  task automatic test_round_robin();
    int acc_n, rsp_n, eg;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    preload(14'h100, 32'hA0A0A0A0);
    preload(14'h200, 32'hB1B1B1B1);
    acc_n = 0;
    rsp_n = 0;
    req_we = 2'b00;
    req_addr[0] = 14'h100;
    req_addr[1] = 14'h200;
    req_valid = 2'b11;
    for (int c = 0; c < 80 && rsp_n < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        eg = acc_n % 2;
        n_cmp++; if (req_ready !== (eg == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant%0d: ready %b want grant %0d", acc_n, req_ready, eg); end
        sb_g.push_back(eg);
        sb.push_back(eg == 1 ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
        acc_n++;
      end
      if (rsp_valid != 2'b00 && sb_g.size() > 0) begin
        eg = sb_g.pop_front();
        n_cmp++; if (rsp_valid !== (eg == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_rsp%0d: valid %b want grant %0d", rsp_n, rsp_valid, eg); end
        n_cmp++; if (rsp_rdata !== sb.pop_front()) begin n_bad++; $display("FAIL rr_data%0d: got %h", rsp_n, rsp_rdata); end
        rsp_n++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    n_cmp++; if (rsp_n !== 4) begin n_bad++; $display("FAIL rr_count: got %0d responses want 4", rsp_n); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_rmw();
    int bad;
    preload(14'h040, 32'h01020304);
    req_we[0] = 1'b1;
    req_addr[0] = 14'h040;
    req_be[0] = 4'b0011;
    req_wdata[0] = 32'hFFFFFFFF;
    req_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_accept: ready %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        rst_n = 1'b0;
        req_valid = 2'b01;
      end
      @(negedge clk);
      if (mem_we !== 1'b0 || rsp_valid !== 2'b00) bad++;
      if (c == 2) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
      end
      if (c == 3) begin
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want 00", req_ready); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL mid_quiet: %0d cycles with we/rsp want 0", bad); end
    n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin n_bad++; $display("FAIL mid_ctrl: busy=%b we=%b rv=%b rdy=%b want 0 0 00 00", busy, mem_we, rsp_valid, req_ready); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0 || rsp_rdata !== '0) begin n_bad++; $display("FAIL mid_data: addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (mem[14'h040] !== 32'h01020304) begin n_bad++; $display("FAIL mid_mem: got %h want 01020304", mem[14'h040]); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_full_store();
    test_partial_store();
    test_zero_be();
    test_round_robin();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencer and two-way arbiter for port b (data port) of the pipeline CPU's dual-port word memory. It shares that single synchronous port between requester 0 (CPU MEM stage) and requester 1 (UART loader/debug). It hides the port's fixed read latency, and it implements byte-enabled stores as read-modify-write over the word-wide port. It handles one transaction at a time and returns a one-hot response to the requester that was granted.

## Interface
- ADDR_W, 14, word address width of the memory port
- DATA_W, 32, data width; equals `DATA_WIDTH
- MEM_LAT, 2, cycles from the address-present cycle to the `mem_rdata`-valid cycle (≥1)

- clk  in  1  single system clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  [1:0]  request valid per requester
- req_ready  out  [1:0]  request accepted this cycle when `req_valid[i] && req_ready[i]`
- req_we  in  [1:0]  1 = store, 0 = load
- req_addr  in  [1:0][ADDR_W-1:0]  word address
- req_be  in  [1:0][3:0]  byte enables for stores, lane-aligned
- req_wdata  in  [1:0][DATA_W-1:0]  store data, lane-aligned
- rsp_valid  out  [1:0]  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  load data, or the final stored word for stores
- mem_addr  out  ADDR_W  to memory `addrb`
- mem_we  out  1  to memory `web`
- mem_wdata  out  DATA_W  to memory `write_datab`
- mem_rdata  in  DATA_W  from memory `datab`
- busy  out  1  high whenever state ≠ IDLE

## Operation
- **States:** IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- **Arbitration (IDLE only).**
  - If exactly one `req_valid` bit is set, grant that requester.
  - If both are set, grant the requester indicated by the round-robin pointer `prio`.
  - `req_ready[g]` = 1 for the granted requester only. It is combinational and is 0 in every non-IDLE state and while `rst_n` = 0.
  - On acceptance, latch `we`/`addr`/`be`/`wdata` and the grant index, and set `prio <= ~g`.
- **Accepted load:** go to RD_ISSUE.
- **Accepted store, be = 4'b1111:** go to WR with `mem_wdata` = wdata.
- **Accepted store, be = 4'b0000:** no-op. Go directly to RESP with no memory access; `rsp_rdata` = 0.
- **Accepted store, any other be (partial):** go to RD_ISSUE, then merge.
- **RD_ISSUE (1 cycle):** `mem_addr` = latched addr, `mem_we` = 0.
- **RD_WAIT (MEM_LAT cycles, counted down):**
  - `mem_addr` is held and `mem_we` = 0.
  - At the end of the last cycle, capture `mem_rdata`.
  - Load: `rsp_rdata <= mem_rdata`, go to RESP.
  - Partial store: merged word = per lane i, `be[i] ? wdata[8i+7:8i] : mem_rdata[8i+7:8i]`. Register it to `mem_wdata` and `rsp_rdata`, then go to WR.
- **WR (1 cycle):** `mem_we` = 1, `mem_addr` = latched addr. For a full store, `rsp_rdata <= wdata`. Go to RESP.
- **RESP (1 cycle):** `rsp_valid[g]` = 1, the other bit stays 0. Go to IDLE.
- **Outputs outside active states:**
  - `mem_we` is 1 only in WR.
  - `mem_addr` and `mem_wdata` hold their last values outside RD_ISSUE, RD_WAIT and WR.
  - `rsp_rdata` holds until the next completion.
- **Responses:** there is no response backpressure; requesters must accept `rsp_valid` unconditionally.
- **Reset mid-operation:**
  - On the next edge with `rst_n` = 0, the state goes to IDLE and the transaction is dropped with no `rsp_valid`.
  - A write already performed in WR stays performed.
  - A partial store interrupted before WR leaves memory unchanged.

## Timing
- Let C0 be the acceptance cycle (`req_valid & req_ready`).
- **Load:** RD_ISSUE C1, RD_WAIT C2–C(1+MEM_LAT), RESP C(2+MEM_LAT). With MEM_LAT = 2, `rsp_valid` is high in C4.
- **Full store:** WR C1 (memory written at the end of C1), RESP C2.
- **Partial store:** RD_ISSUE C1, RD_WAIT C2–C3, WR C4, RESP C5 (MEM_LAT = 2).
- **Zero-be store:** RESP C1.
- **Next acceptance:** earliest is the cycle after RESP (IDLE).
- **Reset values:** state IDLE, `prio` = 0, `mem_addr` = 0, `mem_we` = 0, `mem_wdata` = 0, `rsp_valid` = 2'b00, `rsp_rdata` = 0, `busy` = 0, `req_ready` = 2'b00 during reset.
- A request deasserted by its requester before acceptance is never granted. Requesters hold their fields stable until accepted.

## Test plan
- **Load:** reset, preload mem[0x010] = 0xDEADBEEF; req0 load addr 0x010 → `req_ready[0]` in C0, `mem_we` = 0 throughout, `rsp_valid` = 2'b01 in C4, `rsp_rdata` = 0xDEADBEEF.
- **Full store then load:** req1 store addr 0x3FFF, be 1111, wdata 0x12345678 → `mem_we` = 1 only in C1, `rsp_valid` = 2'b10 in C2. A following load of 0x3FFF returns 0x12345678.
- **Partial store:** mem[0x020] = 0xAABBCCDD; store be 0101, wdata 0x11223344 → `mem_we` = 1 only in C4, `rsp_valid` in C5, `rsp_rdata` = mem[0x020] = 0xAA22CC44.
- **Round-robin:** both requesters hold loads continuously → grants alternate 0, 1, 0, 1. Each `rsp_valid` is one-hot and matches its grant, and `prio` = 0 after reset.
- **Zero be:** store with be 0000 → `rsp_valid` in C1, `mem_we` never asserted, memory unchanged.
- **Reset mid-RMW:** partial store interrupted by `rst_n` = 0 in C3 → no `rsp_valid`, `mem_we` never 1, memory unchanged, all outputs at reset values on the next cycle.
